// File: rtl/lap_sampler.sv
// Stopwatch lap sampler: elapsed-time counter plus debounced lap button that
// emits a one-cycle time snapshot. Define LAP_AUTOREPEAT_EN for held-button auto-repeat.
module lap_sampler #(
    parameter int WIDTH           = 8,
    parameter int TICK_CYCLES     = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic             lap_btn,
    output logic [WIDTH-1:0] time_now,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_out_valid
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } state_t;

    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_time;
    logic             r_sync1, r_sync2;
    state_t           r_state, w_state_nxt;
    logic [DW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             w_cnt_done, w_btn_s, w_capture, w_repeat;
    logic [WIDTH-1:0] r_sample;
    logic             r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_time  <= '0;
        end else if (clear) begin
            r_presc <= '0;
            r_time  <= '0;
        end else if (run) begin
            if (r_presc == PW'(TICK_CYCLES - 1)) begin
                r_presc <= '0;
                r_time  <= r_time + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= lap_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s    = r_sync2;
    // The current cycle's sample counts toward the total, so qualification
    // lands on the DEBOUNCE_CYCLES-th consecutive sample rather than one later.
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_cnt_done = (w_cnt_inc >= DW'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE, S_PRESS_WAIT: begin
                if (w_btn_s) begin
                    if (w_cnt_done) begin
                        w_state_nxt = S_HELD;
                        w_cnt_nxt   = '0;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = S_PRESS_WAIT;
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_HELD: begin
                w_cnt_nxt = '0;
                if (!w_btn_s) begin
                    w_state_nxt = w_cnt_done ? S_IDLE : S_RELEASE_WAIT;
                    w_cnt_nxt   = w_cnt_done ? '0 : w_cnt_inc;
                end
            end
            S_RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef LAP_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] r_rep;
    logic          w_rep_run;

    // Counter only advances while staying in HELD; any entry or exit zeroes it.
    assign w_rep_run = (r_state == S_HELD) && (w_state_nxt == S_HELD);
    assign w_repeat  = w_rep_run && (r_rep == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_rep <= '0;
        else if (w_rep_run)
            r_rep <= w_repeat ? '0 : r_rep + 1'b1;
        else
            r_rep <= '0;
    end
`else
    // Constant-false; REPEAT_CYCLES is referenced so both builds share one interface.
    assign w_repeat = (REPEAT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_capture | w_repeat;
            if (w_capture | w_repeat)
                r_sample <= r_time;
        end
    end

    assign time_now         = r_time;
    assign sample_out       = r_sample;
    assign sample_out_valid = r_valid;

endmodule

// File: tb/tb_lap_sampler.sv
// Scoreboard bench for lap_sampler: stimulus pushes expected captures, a
// negedge monitor pops and checks value and edge of every valid pulse.
module tb_lap_sampler;

    logic       clk = 1'b0;
    logic       reset = 1'b0, run = 1'b0, clear = 1'b0, lap_btn = 1'b0;
    logic       f_run = 1'b0, f_clear = 1'b0;
    logic [7:0] time_now, sample_out, f_time, f_sample;
    logic       sample_out_valid, f_valid;

    always #5 clk = ~clk;

    lap_sampler u_dut (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .lap_btn(lap_btn),
        .time_now(time_now), .sample_out(sample_out), .sample_out_valid(sample_out_valid)
    );

    lap_sampler #(.TICK_CYCLES(2)) u_fast (
        .clk(clk), .reset(reset), .run(f_run), .clear(f_clear), .lap_btn(1'b0),
        .time_now(f_time), .sample_out(f_sample), .sample_out_valid(f_valid)
    );

    typedef struct {
        logic [7:0] t;
        int         e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   edge_n = 0;
    int   m_presc = 0, m_time = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference time counter for u_dut (TICK_CYCLES = 10).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_presc <= 0;
            m_time  <= 0;
        end else if (clear) begin
            m_presc <= 0;
            m_time  <= 0;
        end else if (run) begin
            if (m_presc == 9) begin
                m_presc <= 0;
                m_time  <= (m_time + 1) % 256;
            end else begin
                m_presc <= m_presc + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Time seen just before edge (now + j), assuming run=1 and no clear meanwhile.
    function automatic int pred(input int j);
        return (m_time + (m_presc + j - 1) / 10) % 256;
    endfunction

    task automatic expect_pulse(input int j);
        exp_t e;
        e.t = 8'(pred(j));
        e.e = edge_n + j;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sample_out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse edge=%0d sample=%0d required=no_pulse", edge_n, sample_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_sample", sample_out, e.t);
                chk("pulse_edge", edge_n, e.e);
            end
        end
    end

    initial begin
        step(2);
        chk("rst_time", time_now, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_valid", sample_out_valid, 0);
        chk("rst_fast_time", f_time, 0);

        // 1: free-running count
        reset = 1'b1;
        run   = 1'b1;
        step(35);
        chk("t1_time", time_now, 3);
        chk("t1_sample", sample_out, 0);

        // 2: long hold at time 5, one pulse
        step(15);
        chk("t2_time", time_now, 5);
        lap_btn = 1'b1;
        expect_pulse(6);
        step(12);
        lap_btn = 1'b0;
        step(15);
        chk("t2_sample_hold", sample_out, 5);

        // 3: short glitch, then press with release bounce
        lap_btn = 1'b1;
        step(3);
        lap_btn = 1'b0;
        step(10);
        chk("t3_glitch_sample", sample_out, 5);
        lap_btn = 1'b1;
        expect_pulse(6);
        step(8);
        lap_btn = 1'b0; step(1);
        lap_btn = 1'b1; step(1);
        lap_btn = 1'b0; step(1);
        lap_btn = 1'b1; step(1);
        lap_btn = 1'b0;
        step(15);

        // 4: fast instance wrap and clear-vs-tick priority
        f_run = 1'b1;
        step(510);
        chk("t4_time_255", f_time, 255);
        step(2);
        chk("t4_wrap", f_time, 0);
        step(15);
        chk("t4_time_7", f_time, 7);
        f_clear = 1'b1;
        step(1);
        chk("t4_clear_on_tick", f_time, 0);
        f_clear = 1'b0;
        step(2);
        chk("t4_after_clear", f_time, 1);

        // 5: capture coinciding with tick 9->10
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(94);
        chk("t5_time_pre", time_now, 9);
        lap_btn = 1'b1;
        expect_pulse(6);
        step(6);
        chk("t5_time_post", time_now, 10);
        chk("t5_sample", sample_out, 9);
        lap_btn = 1'b0;
        step(15);

        // reset in the middle of PRESS_WAIT
        lap_btn = 1'b1;
        step(3);
        reset = 1'b0;
        #1;
        chk("t5_rst_time", time_now, 0);
        chk("t5_rst_sample", sample_out, 0);
        chk("t5_rst_valid", sample_out_valid, 0);
        lap_btn = 1'b0;
        step(2);
        reset = 1'b1;
        step(15);
        chk("t5_post_rst_sample", sample_out, 0);

        // 6: long hold, auto-repeat when enabled
        lap_btn = 1'b1;
        expect_pulse(6);
`ifdef LAP_AUTOREPEAT_EN
        expect_pulse(26);
        expect_pulse(46);
`endif
        step(56);
        lap_btn = 1'b0;
        step(30);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
